// File: rtl/conv2d_mac_engine.sv
// Sequential KSIZE x KSIZE multi-channel convolution MAC: one kernel row per clock, valid/ready in and out.
// Optional CONV_RELU_EN: clamp negative signed-mode results to zero when loaded into result.
module conv2d_mac_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int KSIZE        = 3,
  parameter int CHANNELS     = 1,
  parameter int RESULT_WIDTH = 20
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   filter_flat,
  input  logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   image_flat,
  input  logic                                signed_mode,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [RESULT_WIDTH-1:0]             result,
  output logic                                busy
);

  localparam int N     = KSIZE * KSIZE * DATA_WIDTH;
  localparam int ROW_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(KSIZE - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                  state, state_next;
  logic [N-1:0]            filt_q, img_q;
  logic                    signed_q;
  logic [ROW_W-1:0]        row;
  logic [CH_W-1:0]         ch;
  logic [RESULT_WIDTH-1:0] acc, row_sum, acc_next, load_val;
  logic [DATA_WIDTH-1:0]   f_el, i_el;
  logic [RESULT_WIDTH-1:0] f_ext, i_ext;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid) state_next = S_MAC;
      S_MAC:   if (row == ROW_LAST) state_next = (ch == CH_LAST) ? S_OUT : S_IDLE;
      S_OUT:   if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_OUT);
    busy      = (state != S_IDLE) || (ch != '0);
  end

  // Operands are widened to RESULT_WIDTH first, so the truncated product is already the wrapped value.
  always_comb begin
    row_sum = '0;
    f_el    = '0;
    i_el    = '0;
    f_ext   = '0;
    i_ext   = '0;
    for (int unsigned c = 0; c < KSIZE; c++) begin
      f_el  = filt_q[(32'(row) * KSIZE + c) * DATA_WIDTH +: DATA_WIDTH];
      i_el  = img_q [(32'(row) * KSIZE + c) * DATA_WIDTH +: DATA_WIDTH];
      f_ext = signed_q ? {{(RESULT_WIDTH-DATA_WIDTH){f_el[DATA_WIDTH-1]}}, f_el}
                       : {{(RESULT_WIDTH-DATA_WIDTH){1'b0}}, f_el};
      i_ext = signed_q ? {{(RESULT_WIDTH-DATA_WIDTH){i_el[DATA_WIDTH-1]}}, i_el}
                       : {{(RESULT_WIDTH-DATA_WIDTH){1'b0}}, i_el};
      row_sum = row_sum + f_ext * i_ext;
    end
    acc_next = acc + row_sum;
    load_val = acc_next;
`ifdef CONV_RELU_EN
    if (signed_q && acc_next[RESULT_WIDTH-1]) load_val = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q   <= '0;
      img_q    <= '0;
      signed_q <= 1'b0;
      row      <= '0;
      ch       <= '0;
      acc      <= '0;
      result   <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          filt_q <= filter_flat;
          img_q  <= image_flat;
          row    <= '0;
          if (ch == '0) begin
            acc      <= '0;
            signed_q <= signed_mode;
          end
        end
        S_MAC: begin
          acc <= acc_next;
          row <= row + 1'b1;
          if (row == ROW_LAST) begin
            row <= '0;
            if (ch == CH_LAST) result <= load_val;
            else               ch     <= ch + 1'b1;
          end
        end
        S_OUT: if (out_ready) ch <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/conv2d_mac_engine.md
# conv2d_mac_engine

Parametrised, sequential successor to the combinational 3x3 convolution accelerator. It accepts one KSIZE x KSIZE filter/image patch pair per input channel over a valid/ready handshake. It multiply-accumulates one kernel row per clock and sums across CHANNELS input channels. It returns a single dot-product result over an output valid/ready handshake. It sits between the patch-fetch logic and the result writeback in the AI accelerator datapath.

## Interface
- DATA_WIDTH, 8: bits per filter/image element.
- KSIZE, 3: kernel edge length (KSIZE x KSIZE elements per channel), 1..7.
- CHANNELS, 1: input channels summed into one result, 1..16.
- RESULT_WIDTH, 20: accumulator/result width. Full precision needs ≥ 2*DATA_WIDTH + clog2(KSIZE*KSIZE*CHANNELS).
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  filter_flat/image_flat/signed_mode valid.
- in_ready  out  1  engine accepts a channel patch this cycle.
- filter_flat  in  KSIZE*KSIZE*DATA_WIDTH  filter; element (r,c) at bits [(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH].
- image_flat  in  KSIZE*KSIZE*DATA_WIDTH  image patch, same packing.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled on channel-0 acceptance only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- result  out  RESULT_WIDTH  accumulated dot product.
- busy  out  1  high whenever state ≠ S_IDLE or channel count ≠ 0.

## Operation
- States: S_IDLE, S_MAC, S_OUT. Reset: S_IDLE, ch=0, row=0, acc=0, result=0, out_valid=0, in_ready=1, busy=0.
- S_IDLE: in_ready=1. On in_valid&&in_ready, register both patches into local storage. Enter S_MAC with row=0. If ch==0, also clear acc and latch signed_mode.
- S_MAC: in_ready=0. Each cycle acc += sum over c of filter[row][c]*image[row][c], then row++.
- After row KSIZE-1:
  - If ch==CHANNELS-1: go to S_OUT, load result=acc, set out_valid=1.
  - Otherwise: ch++ and return to S_IDLE.
- S_OUT: in_ready=0. result and out_valid are held stable while out_ready=0. On out_ready: out_valid=0, ch=0, go to S_IDLE.
- Arithmetic:
  - Unsigned mode zero-extends operands.
  - Signed mode sign-extends operands and products to RESULT_WIDTH.
  - Accumulation wraps modulo 2^RESULT_WIDTH; no saturation, no overflow flag.
- Inputs are sampled only on the accepting edge. Later changes to filter_flat/image_flat do not affect the in-flight computation.
- rst at any time (mid-MAC, in S_OUT, between channels) aborts the operation. It restores reset values on the next edge, and partial sums are discarded.

## Timing
- Accept at edge T: rows are accumulated on edges T+1..T+KSIZE.
- For the last channel, out_valid is high after edge T+KSIZE. With defaults, the result is visible 3 edges after acceptance.
- Per-channel occupancy is KSIZE+1 cycles including the S_IDLE accept cycle. The next channel can be accepted in the cycle immediately after the last MAC edge.
- Throughput with CHANNELS=1 and out_ready tied high: one result per KSIZE+2 cycles.
- in_ready depends only on state, never combinationally on in_valid. out_valid depends only on state.
- out_valid and out_ready high in the same cycle completes the transfer on that edge. in_ready rises after that edge.

## Configuration
- CONV_RELU_EN defined: in signed mode, a negative accumulated value is replaced by 0 when loaded into result. Unsigned mode is unaffected, and the latency is identical.
- CONV_RELU_EN undefined: result is the raw accumulator in both modes.

## Test plan
- Defaults, unsigned; only filter/image (0,0)=1, rest 0 -> result=1, out_valid exactly 3 edges after acceptance.
- All elements 1 -> 9. Then filter=2, image=3 -> 54 (0x00036). Then all 0xFF -> 585225 (0x8EE09).
- Signed, filter all 0xFF (-1), image all 3:
  - Without CONV_RELU_EN -> result=0xFFFE5 (-27).
  - With CONV_RELU_EN -> 0.
- CHANNELS=2: ch0 all ones, ch1 filter=2/image=3 -> 63.
  - in_ready is low during MAC, and out_valid appears only after the second channel.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> result stays 54, in_ready=0, no new patch accepted. out_ready=1 -> out_valid drops and in_ready rises next cycle.
- Assert rst for one cycle at row 1 of a MAC -> next cycle S_IDLE, result=0, busy=0. A fresh all-ones patch then yields 9.
